// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package fetch_pkg;
    localparam int HW_W = 16;

    typedef enum logic {
        F_IDLE,
        F_REQ
    } fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH x 16-bit halfword FIFO; accepts up to two entries per cycle (push0, then push1).
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            push0,
    input  logic            push1,
    input  logic            pop,
    input  logic [HW_W-1:0] din0,
    input  logic [HW_W-1:0] din1,
    output logic [CW-1:0]   count,
    output logic [HW_W-1:0] head
);
    logic [HW_W-1:0] mem_q [DEPTH];
    logic [HW_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   wr_ptr_p1;
    logic [CW-1:0]   count_q, count_d;

    assign wr_ptr_p1 = wr_ptr_q + AW'(1);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
            if (push0) mem_d[wr_ptr_q] = din0;
            if (push1) mem_d[wr_ptr_p1] = din1;
            wr_ptr_d = wr_ptr_q + AW'(push0) + AW'(push1);
            count_d  = count_q + CW'(push0) + CW'(push1) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];
endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch sequencer: fetches 32-bit words, queues 16-bit halfwords for the decoder.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int             RV           = 32,
    parameter int             DEPTH        = 4,
    parameter logic [RV-1:0]  RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            ifetch_req,
    output logic [RV-1:0]   ifetch_addr,
    input  logic            ifetch_ack,
    input  logic [31:0]     ifetch_data,
    input  logic            dec_ready,
    input  logic            flush,
    input  logic [RV-1:0]   flush_pc,
    output logic [HW_W-1:0] ins,
    output logic [RV-1:0]   ins_pc,
    output logic            idone
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [RV-1:0]   fetch_pc_q, fetch_pc_d;
    logic [RV-1:0]   head_pc_q, head_pc_d;
    logic [RV-1:0]   req_addr_q, req_addr_d;
    logic            drop_q, drop_d;

    logic [CW-1:0]   fifo_count;
    logic [HW_W-1:0] fifo_head;
    logic            push0, push1;
    logic [HW_W-1:0] din0, din1;
    logic            empty, room;
    logic [RV-1:0]   flush_tgt, fetch_al;

    assign empty     = (fifo_count == '0);
    assign room      = (fifo_count <= CW'(DEPTH - 2));
    assign flush_tgt = flush_pc & ~RV'(1);
    assign fetch_al  = fetch_pc_q & ~RV'(3);
    assign idone     = !empty && dec_ready && !flush;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        head_pc_d  = head_pc_q;
        req_addr_d = req_addr_q;
        drop_d     = drop_q;
        push0      = 1'b0;
        push1      = 1'b0;
        din0       = ifetch_data[15:0];
        din1       = ifetch_data[31:16];
        if (flush) begin
            fetch_pc_d = flush_tgt;
            head_pc_d  = flush_tgt;
            // An outstanding fetch that is not completing now must be discarded later.
            drop_d     = (state_q == F_REQ) && !ifetch_ack;
            if (state_q == F_REQ && ifetch_ack) state_d = F_IDLE;
        end else begin
            if (idone) head_pc_d = head_pc_q + RV'(2);
            if (state_q == F_IDLE) begin
                if (room) begin
                    state_d    = F_REQ;
                    req_addr_d = fetch_al;
                end
            end else if (ifetch_ack) begin
                state_d = F_IDLE;
                drop_d  = 1'b0;
                if (!drop_q) begin
                    fetch_pc_d = fetch_al + RV'(4);
                    push0      = 1'b1;
                    if (fetch_pc_q[1]) din0  = ifetch_data[31:16];
                    else               push1 = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= F_IDLE;
            fetch_pc_q <= RESET_VECTOR;
            head_pc_q  <= RESET_VECTOR;
            req_addr_q <= RESET_VECTOR & ~RV'(3);
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            head_pc_q  <= head_pc_d;
            req_addr_q <= req_addr_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push0 (push0),
        .push1 (push1),
        .pop   (idone),
        .din0  (din0),
        .din1  (din1),
        .count (fifo_count),
        .head  (fifo_head)
    );

    assign ifetch_req  = (state_q == F_REQ);
    assign ifetch_addr = req_addr_q;
    assign ins         = fifo_head;
    assign ins_pc      = head_pc_q;
endmodule
